hex_entry_editor: RTL
=====================

Name: hex_entry_editor

Overview:
Button-driven editor that builds a 32-bit value one hex nibble at a time and commits it to the rest of the design. It is the input counterpart to the scrolling nibble display: the display reads a 32-bit word nibble by nibble, and this block writes one. It exports the selected nibble index and value so a seven-segment driver can show the edit cursor. It conditions raw board buttons internally with synchronisers, debounce and edge detection.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable clk cycles before a button level is accepted.
CNT_W, 18, width of each debounce counter; must hold DEBOUNCE_CYCLES.
TIMEOUT_CYCLES, 100000000, idle cycles before an edit is aborted. Used only with EDIT_TIMEOUT_EN.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_right  in  1  raw button: cursor to next-higher nibble
btn_left  in  1  raw button: cursor to next-lower nibble
btn_up  in  1  raw button: increment selected nibble
btn_down  in  1  raw button: decrement selected nibble
btn_center  in  1  raw button: enter edit / commit
value_out  out  32  last committed value
value_valid  out  1  one-cycle pulse when value_out updates
edit_active  out  1  high while in EDIT
nibble_sel  out  3  cursor index, 0 = bits [3:0], 7 = bits [31:28]
nibble_val  out  4  working-register nibble at nibble_sel

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high on rst. All flops clear on rst assertion, independent of clk.
- Reset values:
  - value_out = 0, value_valid = 0, edit_active = 0, nibble_sel = 0, nibble_val = 0.
  - Working register = 0, FSM = IDLE, debounced levels = 0, counters = 0.
- Button conditioning, per button, identical and independent:
  - 2-FF synchroniser, then debounce.
  - Debounce: when the synced level differs from the debounced level, the counter increments. It resets to 0 when the levels match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synced level and the counter clears.
  - Press pulse = rising edge of the debounced level; one cycle wide. Release produces no pulse.
  - Latency from a clean raw rising edge to the press pulse = DEBOUNCE_CYCLES + 3 cycles.
  - Holding a button produces exactly one pulse; there is no auto-repeat.
- FSM states: IDLE, EDIT, COMMIT.
- IDLE:
  - edit_active = 0.
  - Center pulse: working register <= value_out, nibble_sel <= 0, go to EDIT.
  - All other pulses are ignored.
- EDIT:
  - edit_active = 1.
  - Right pulse: nibble_sel + 1, saturating at 7.
  - Left pulse: nibble_sel − 1, saturating at 0.
  - Up pulse: selected nibble + 1 mod 16 (F -> 0).
  - Down pulse: selected nibble − 1 mod 16 (0 -> F).
  - Center pulse: go to COMMIT.
- COMMIT (exactly one cycle):
  - value_out <= working register; value_valid = 1 during the following cycle.
  - Go to IDLE.
  - Pulses arriving in COMMIT are dropped.
- Simultaneous pulses in the same cycle:
  - Center has priority; all other pulses in that cycle are ignored.
  - Left + right together: no cursor move.
  - Up + down together: no nibble change.
  - Modify + move together: the nibble change applies at the old nibble_sel, then the cursor moves.
- nibble_val is combinational from the working register and nibble_sel: zero latency, valid in every state. In IDLE the working register holds the last loaded/committed value.
- value_out changes only on COMMIT, so an aborted or reset edit never alters it except through reset.
- rst mid-edit: immediate return to IDLE with every register at its reset value. Any pulse in the reset-release cycle is discarded.

Optional Feature:
EDIT_TIMEOUT_EN:
- Defined:
  - A timeout counter runs while in EDIT and clears on any press pulse.
  - On reaching TIMEOUT_CYCLES, the FSM returns to IDLE without committing.
  - The working register reloads from value_out, nibble_sel returns to 0, and value_valid stays 0.
- Undefined: the counter is absent and EDIT persists indefinitely.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES = 4, TIMEOUT_CYCLES = 50.
1. Reset, then hold btn_center high for 10 cycles -> one press pulse 7 cycles after the edge; edit_active = 1, nibble_sel = 0, nibble_val = 0. A 3-cycle glitch on btn_up -> no change.
2. In EDIT: 3× up, right, 2× down, center -> value_out = 0x000000E3; value_valid high for exactly 1 cycle; edit_active = 0.
3. Re-enter EDIT and press right 9× -> nibble_sel saturates at 7. Press up -> value nibble [31:28] = 1. Press left 9× -> nibble_sel = 0.
4. Force same-cycle pulses: up + right from nibble_sel = 2 -> nibble 2 increments, then nibble_sel = 3. Left + right together -> nibble_sel unchanged. Center + up together -> COMMIT with no increment.
5. Assert rst asynchronously mid-EDIT after edits -> all outputs 0 before the next clk edge; value_out = 0; no value_valid.
6. With EDIT_TIMEOUT_EN defined: commit 0x12345678, re-enter EDIT, press up, then idle 50 cycles -> state IDLE, value_out still 0x12345678, value_valid never asserted. Without the macro -> EDIT held after 200 idle cycles.

Source files
------------

// File: rtl/hex_entry_editor.sv
// Button-driven hex editor: builds a 32-bit value nibble by nibble and commits it.
// Optional macro EDIT_TIMEOUT_EN aborts an edit after TIMEOUT_CYCLES idle cycles.
module hex_entry_editor #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned CNT_W           = 18,
   parameter int unsigned TIMEOUT_CYCLES  = 100000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_right,
   input  logic        btn_left,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_center,
   output logic [31:0] value_out,
   output logic        value_valid,
   output logic        edit_active,
   output logic [2:0]  nibble_sel,
   output logic [3:0]  nibble_val
);

   localparam int BTN_R = 0;
   localparam int BTN_L = 1;
   localparam int BTN_D = 2;
   localparam int BTN_U = 3;
   localparam int BTN_C = 4;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EDIT   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2**CNT_W - 1) || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("hex_entry_editor: CNT_W cannot hold DEBOUNCE_CYCLES or a cycle count is zero");
   end

   logic [4:0]            w_btn_raw;
   logic [4:0]            r_sync1;
   logic [4:0]            r_sync2;
   logic [4:0]            r_deb;
   logic [4:0]            r_deb_d;
   logic [4:0][CNT_W-1:0] r_cnt;
   logic [4:0]            w_press;

   assign w_btn_raw = {btn_center, btn_up, btn_down, btn_left, btn_right};

   // The debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         r_deb_d <= '0;
         r_cnt   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values, as real hardware does.
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
         r_deb_d <= r_deb;
         for (int i = 0; i < 5; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == DEB_LAST) begin
               r_deb[i] <= r_sync2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_press = r_deb & ~r_deb_d;

   logic        w_up;
   logic        w_dn;
   logic        w_left;
   logic        w_right;
   logic        w_center;
   logic        w_timeout;
   logic [1:0]  r_state;
   logic [31:0] r_work;
   logic [31:0] r_value;
   logic [2:0]  r_sel;
   logic        r_valid;
   logic [4:0]  w_nib_idx;
   logic [3:0]  w_nib;

   assign w_up      = w_press[BTN_U];
   assign w_dn      = w_press[BTN_D];
   assign w_left    = w_press[BTN_L];
   assign w_right   = w_press[BTN_R];
   assign w_center  = w_press[BTN_C];
   assign w_nib_idx = {r_sel, 2'b00};
   assign w_nib     = r_work[w_nib_idx +: 4];

`ifdef EDIT_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] r_to_cnt;

   assign w_timeout = (r_state == S_EDIT) && !(|w_press) && (r_to_cnt == TO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to_cnt <= '0;
      end else if (r_state != S_EDIT || (|w_press) || w_timeout) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // Center wins over every other press; opposing presses cancel each other.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_work  <= '0;
         r_value <= '0;
         r_sel   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_center) begin
                  r_work  <= r_value;
                  r_sel   <= '0;
                  r_state <= S_EDIT;
               end
            end
            S_EDIT: begin
               if (w_center) begin
                  r_state <= S_COMMIT;
               end else if (w_timeout) begin
                  r_work  <= r_value;
                  r_sel   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  // Nibble edit uses the pre-move cursor, then the cursor moves.
                  if (w_up && !w_dn) begin
                     r_work[w_nib_idx +: 4] <= w_nib + 4'd1;
                  end else if (w_dn && !w_up) begin
                     r_work[w_nib_idx +: 4] <= w_nib - 4'd1;
                  end
                  if (w_right && !w_left && r_sel != 3'd7) begin
                     r_sel <= r_sel + 3'd1;
                  end else if (w_left && !w_right && r_sel != 3'd0) begin
                     r_sel <= r_sel - 3'd1;
                  end
               end
            end
            S_COMMIT: begin
               r_value <= r_work;
               r_valid <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign value_out   = r_value;
   assign value_valid = r_valid;
   assign edit_active = (r_state == S_EDIT);
   assign nibble_sel  = r_sel;
   assign nibble_val  = w_nib;

endmodule
